// File: rtl/fab_reset_sequencer.sv
// fab_reset_sequencer: fabric reset generator behind the MSS CCC.
// Qualifies MSS reset, CCC lock and pushbutton; releases domains staggered.
module fab_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int USE_LOCK        = 0,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic                   FAB_CLK,
  input  logic                   M2F_RESET_N,
  input  logic                   FAB_LOCK,
  input  logic                   SW_RESET_N,
  input  logic                   SOFT_RST_REQ,
  output logic [NUM_DOMAINS-1:0] RST_N_OUT,
  output logic                   READY,
  output logic                   LOCK_LOST,
  output logic                   LOCK_ERR,
  output logic [2:0]             STATE
);

  localparam int REL_SPAN = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int HL_MAX   = (HOLD_CYCLES > LOCK_TIMEOUT) ?
                            HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (HL_MAX > REL_SPAN) ? HL_MAX : REL_SPAN;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int DW       = (DEBOUNCE_CYCLES > 1) ?
                            $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RUN_AT    =
    CW'((NUM_DOMAINS - 1) * STAGGER_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD      = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_sw_sync;
  logic [DW-1:0]          r_deb_cnt;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_inc;
  logic [CW-1:0]          w_cnt_next;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic [NUM_DOMAINS-1:0] w_rst_n_next;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic                   r_lock_err;

  logic w_rst_sync;
  logic w_lock_sync;
  logic w_sw_sync;
  logic w_pressed;
  logic w_lock_lost;
  logic w_set_lost;
  logic w_set_err;

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_rst_sync  <= '0;
      r_lock_sync <= '0;
      r_sw_sync   <= '1;
    end else begin
      r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], FAB_LOCK};
      r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], SW_RESET_N};
    end
  end

  assign w_rst_sync  = r_rst_sync[SYNC_STAGES-1];
  assign w_lock_sync = r_lock_sync[SYNC_STAGES-1];
  assign w_sw_sync   = r_sw_sync[SYNC_STAGES-1];

  // Press is the DEBOUNCE_CYCLES-th consecutive low sample and later ones.
  assign w_pressed = !w_sw_sync && (r_deb_cnt == DEB_LAST);

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N)
      r_deb_cnt <= '0;
    else if (w_sw_sync)
      r_deb_cnt <= '0;
    else if (r_deb_cnt != DEB_LAST)
      r_deb_cnt <= r_deb_cnt + 1'b1;
  end

  // After a lock timeout the clock is run unqualified, so stop monitoring.
  assign w_lock_lost = (USE_LOCK != 0) && !r_lock_err && !w_lock_sync;

  assign w_cnt_inc = (r_cnt == CNT_TOP) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = w_cnt_inc;
    w_rst_n_next = r_rst_n;
    w_set_lost   = 1'b0;
    w_set_err    = 1'b0;
    unique case (1'b1)
      (r_state == S_RESET): begin
        w_cnt_next   = '0;
        w_rst_n_next = '0;
        if (w_rst_sync)
          w_next = (USE_LOCK != 0) ? S_WAIT_LOCK : S_HOLD;
      end
      (r_state == S_WAIT_LOCK): begin
        w_rst_n_next = '0;
        if (w_lock_sync || w_pressed || (r_cnt == LOCK_LAST)) begin
          w_next     = S_HOLD;
          w_cnt_next = '0;
          w_set_err  = !w_lock_sync && (r_cnt == LOCK_LAST);
        end
      end
      (r_state == S_HOLD): begin
        w_rst_n_next = '0;
        if (w_lock_lost) begin
          w_next     = S_WAIT_LOCK;
          w_cnt_next = '0;
        end else if (w_pressed) begin
          w_cnt_next = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_next          = S_RELEASE;
          w_cnt_next      = '0;
          w_rst_n_next[0] = 1'b1;
        end
      end
      (r_state == S_RELEASE): begin
        if (w_lock_lost) begin
          w_next       = S_WAIT_LOCK;
          w_cnt_next   = '0;
          w_rst_n_next = '0;
        end else if (w_pressed) begin
          w_next       = S_HOLD;
          w_cnt_next   = '0;
          w_rst_n_next = '0;
        end else begin
          for (int i = 1; i < NUM_DOMAINS; i++)
            if (w_cnt_inc == CW'(i * STAGGER_CYCLES))
              w_rst_n_next[i] = 1'b1;
          if (w_cnt_inc == RUN_AT) begin
            w_next     = S_RUN;
            w_cnt_next = '0;
          end
        end
      end
      (r_state == S_RUN): begin
        w_cnt_next   = '0;
        w_rst_n_next = '1;
        if (w_lock_lost) begin
          w_next       = S_WAIT_LOCK;
          w_set_lost   = 1'b1;
          w_rst_n_next = '0;
        end else if (w_pressed || SOFT_RST_REQ) begin
          w_next       = S_HOLD;
          w_rst_n_next = '0;
        end
      end
      default: begin
        w_next       = S_RESET;
        w_cnt_next   = '0;
        w_rst_n_next = '0;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_state     <= S_RESET;
      r_cnt       <= '0;
      r_rst_n     <= '0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_lock_err  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_rst_n     <= w_rst_n_next;
      r_ready     <= (w_next == S_RUN);
      r_lock_lost <= r_lock_lost | w_set_lost;
      r_lock_err  <= r_lock_err | w_set_err;
    end
  end

  assign RST_N_OUT = r_rst_n;
  assign READY     = r_ready;
  assign LOCK_LOST = r_lock_lost;
  assign LOCK_ERR  = r_lock_err;
  assign STATE     = r_state;

endmodule
